// File: rtl/seq_alu_cc.sv
// Multi-cycle Y86-64 integer ALU: ADD/SUB/AND/XOR computed CHUNK bits per clock,
// LSB-first with a rippled carry, producing result plus ZF/SF/OF condition codes.
//
// state | meaning
// IDLE  | ready for an operation; operands latched on in_valid
// RUN   | one CHUNK slice computed per cycle, carry rippled between slices
// DONE  | result and flags presented with out_valid until out_ready
module seq_alu_cc #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_nxt;
  logic [1:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  int               base;
  logic [CHUNK-1:0] a_s, b_s, slice;
  logic [CHUNK:0]   sum;
  logic             arith;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // One slice of the datapath; b_q is already inverted for SUB so SUB is a+~b+1.
  always_comb begin
    base  = int'(cnt_q) * CHUNK;
    a_s   = a_q[base +: CHUNK];
    b_s   = b_q[base +: CHUNK];
    sum   = {1'b0, a_s} + {1'b0, b_s} + {{CHUNK{1'b0}}, carry_q};
    case (op_q)
      OP_ADD:  slice = sum[CHUNK-1:0];
      OP_SUB:  slice = sum[CHUNK-1:0];
      OP_AND:  slice = a_s & b_s;
      OP_XOR:  slice = a_s ^ b_s;
      default: slice = sum[CHUNK-1:0];
    endcase
    work_nxt              = work_q;
    work_nxt[base +: CHUNK] = slice;
    last  = (cnt_q == CW'(NCHUNK - 1));
    arith = ~op_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      result  <= '0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      of      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (op == OP_SUB) ? ~b : b;
            op_q    <= op;
            carry_q <= (op == OP_SUB);
            cnt_q   <= '0;
            work_q  <= '0;
          end
        end
        S_RUN: begin
          work_q  <= work_nxt;
          carry_q <= sum[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          // With b pre-inverted, SUB overflow reduces to the ADD rule on a_q/b_q.
          if (last) begin
            result <= work_nxt;
            zf     <= ~|work_nxt;
            sf     <= work_nxt[WIDTH-1];
            of     <= arith && (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_cc.sv
// Self-checking bench for seq_alu_cc: directed corner cases plus randomized ops
// compared against an integer-arithmetic reference model.
module tb_seq_alu_cc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic        zf, sf, of;

  logic        v64, rdy64, ov64, ordy64, zf64, sf64, of64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, res64;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  seq_alu_cc #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zf(zf), .sf(sf), .of(of)
  );

  seq_alu_cc #(.WIDTH(64), .CHUNK(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64), .op(op64),
    .a(a64), .b(b64), .out_valid(ov64), .out_ready(ordy64), .result(res64),
    .zf(zf64), .sf(sf64), .of(of64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {zf, sf, of, result} from signed integer arithmetic.
  function automatic logic [34:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, s;
    logic [31:0] r;
    logic ov;
    sx = $signed(x);
    sy = $signed(y);
    ov = 1'b0;
    case (o)
      2'd0: s = sx + sy;
      2'd1: s = sx - sy;
      2'd2: s = longint'(x & y);
      default: s = longint'(x ^ y);
    endcase
    r = s[31:0];
    if (o < 2'd2) ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r == 32'd0, r[31], ov, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for out_valid, check latency and outputs (stays in DONE).
  task automatic start32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
    logic [34:0] e;
    int cyc;
    e = model(o, x, y);
    cyc = 0;
    while (!in_ready && cyc < 20) begin tick(); cyc++; end
    check({tag, " rdy"}, in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
    check({tag, " lat"}, 64'(cyc), 64'd4);
    check({tag, " res"}, result, e[31:0]);
    check({tag, " zf"}, zf, e[34]);
    check({tag, " sf"}, sf, e[33]);
    check({tag, " of"}, of, e[32]);
  endtask

  task automatic ack32(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " ack"}, out_valid, 0);
  endtask

  logic [31:0] held, ra, rb;
  logic [1:0]  ro;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;
    v64 = 1'b0; ordy64 = 1'b0; op64 = 2'd0; a64 = '0; b64 = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst flags", {zf, sf, of}, 3'b000);

    start32(2'd0, 32'h7FFFFFFF, 32'h1, "add_ovf");
    check("add_ovf const", {zf, sf, of, result}, {3'b011, 32'h80000000});
    ack32("add_ovf");
    start32(2'd0, 32'h80000000, 32'hFFFFFFFF, "add_negovf");
    check("add_negovf const", {sf, of, result}, {2'b01, 32'h7FFFFFFF});
    ack32("add_negovf");
    start32(2'd1, 32'd9, 32'd9, "sub_zero");
    check("sub_zero const", {zf, of, result}, {2'b10, 32'h0});
    ack32("sub_zero");
    start32(2'd1, 32'd2, 32'd13, "sub_neg");
    check("sub_neg const", {sf, of, result}, {2'b10, 32'hFFFFFFF5});
    ack32("sub_neg");
    start32(2'd2, 32'h1001, 32'h1111, "and");
    check("and const", result, 32'h1001);
    ack32("and");
    start32(2'd3, 32'hFFFF0000, 32'hFFFF0000, "xor_zero");
    check("xor_zero const", {zf, of, result}, {2'b10, 32'h0});
    ack32("xor_zero");

    // Backpressure: DONE held 5 cycles while in_valid pulses are offered.
    start32(2'd0, 32'h12345678, 32'h11111111, "bp");
    held = result;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 2'd3; a = $urandom; b = $urandom;
      tick();
      in_valid = 1'b0;
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
      check("bp result", result, held);
    end
    ack32("bp");
    check("bp holdover", result, held);
    tick(); tick();
    check("bp not queued", out_valid, 0);
    check("bp idle", in_ready, 1);

    // Reset during the second RUN cycle discards the operation.
    op = 2'd0; a = 32'd100; b = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run in_ready", in_ready, 1);
    check("rst_run out_valid", out_valid, 0);
    check("rst_run result", result, 0);
    check("rst_run flags", {zf, sf, of}, 3'b000);
    repeat (6) begin
      tick();
      check("rst_run no output", out_valid, 0);
    end
    start32(2'd0, 32'd23, 32'd0, "post_rst");
    check("post_rst const", result, 32'd23);
    ack32("post_rst");

    // Randomized ops with corner-biased operands and random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h7FFFFFFF : 32'h80000000;
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h00000001;
      if ($urandom_range(0, 7) == 0) rb = ra;
      start32(ro, ra, rb, "rand");
      repeat ($urandom_range(0, 2)) tick();
      ack32("rand");
    end

    // 64-bit single-chunk instance: one-cycle latency.
    op64 = 2'd0; a64 = 64'h7FFFFFFFFFFFFFFF; b64 = 64'd1; v64 = 1'b1;
    tick();
    v64 = 1'b0;
    check("w64 busy", rdy64, 0);
    tick();
    check("w64 lat", ov64, 1);
    check("w64 res", res64, 64'h8000000000000000);
    check("w64 flags", {zf64, sf64, of64}, 3'b011);
    ordy64 = 1'b1;
    tick();
    ordy64 = 1'b0;
    check("w64 ack", ov64, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
